// File: rtl/noc_vc_input_unit.sv
//------------------------------------------------------------------------------
// Module   : noc_vc_input_unit
// Purpose  : Router input port holding NUM_VC virtual-channel FIFOs, each with
//            its own RC/VA/SA state machine, output-VC rewrite and credit return.
//            Optional: NOC_IU_PROTO_CHECK_EN adds a sticky proto_err output.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module noc_vc_input_unit #(
  parameter int D_WIDTH   = 32,
  parameter int NUM_VC    = 4,
  parameter int VID_BITS  = 2,
  parameter int DEPTH     = 4,
  parameter int DEST_BITS = 4,
  parameter int CNT_BITS  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [D_WIDTH-1:0]           in_flit,
  output logic [NUM_VC-1:0]            rc_req,
  input  logic [NUM_VC-1:0]            rc_gnt,
  input  logic [DEST_BITS-1:0]         rc_route_i,
  output logic [NUM_VC-1:0]            va_req,
  input  logic [NUM_VC-1:0]            va_gnt,
  input  logic [VID_BITS-1:0]          va_ovid_i,
  output logic [NUM_VC-1:0]            sa_req,
  input  logic [NUM_VC-1:0]            sa_gnt,
  output logic                         out_valid,
  output logic [D_WIDTH-1:0]           out_flit,
  output logic [DEST_BITS-1:0]         out_route,
  output logic                         credit_valid,
  output logic [VID_BITS-1:0]          credit_vid,
  output logic [NUM_VC*CNT_BITS-1:0]   vc_count,
`ifdef NOC_IU_PROTO_CHECK_EN
  output logic                         proto_err,
`endif
  output logic                         ovf_err
);

  localparam int                  c_ptr_bits = $clog2(DEPTH);
  localparam logic [CNT_BITS-1:0] c_depth    = CNT_BITS'(DEPTH);
  localparam logic [2:0]          c_st_rc    = 3'b001;
  localparam logic [2:0]          c_st_va    = 3'b010;
  localparam logic [2:0]          c_st_act   = 3'b100;
  // Bit position of the type MSB: 1 for head/body, 0 for tail/single.
  localparam int                  c_type_msb = D_WIDTH - VID_BITS - 1;

  logic [D_WIDTH-1:0]    r_mem      [NUM_VC][DEPTH];
  logic [c_ptr_bits-1:0] r_rd_ptr   [NUM_VC];
  logic [c_ptr_bits-1:0] r_wr_ptr   [NUM_VC];
  logic [CNT_BITS-1:0]   r_count    [NUM_VC];
  logic [2:0]            r_state    [NUM_VC];
  logic [2:0]            w_state_nxt[NUM_VC];
  logic [DEST_BITS-1:0]  r_route    [NUM_VC];
  logic [VID_BITS-1:0]   r_ovid     [NUM_VC];
  logic [D_WIDTH-1:0]    w_head     [NUM_VC];

  logic [VID_BITS-1:0]   w_in_vid;
  logic [NUM_VC-1:0]     w_empty;
  logic [NUM_VC-1:0]     w_full;
  logic [NUM_VC-1:0]     w_wr;
  logic [NUM_VC-1:0]     w_sa_valid;
  logic [NUM_VC-1:0]     w_pop;
  logic                  w_accept;
  logic                  w_sel_any;
  logic [VID_BITS-1:0]   w_sel_idx;
  logic [D_WIDTH-1:0]    w_fwd_flit;

  assign w_in_vid = in_flit[D_WIDTH-1 -: VID_BITS];

  always_comb begin
    w_empty  = '0;
    w_full   = '0;
    w_wr     = '0;
    vc_count = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      w_empty[i] = (r_count[i] == '0);
      w_full[i]  = (r_count[i] == c_depth);
      w_head[i]  = r_mem[i][r_rd_ptr[i]];
      vc_count[i*CNT_BITS +: CNT_BITS] = r_count[i];
    end
    // A full VC still takes the flit when its head leaves in the same cycle.
    w_accept = in_valid & (~w_full[w_in_vid] | w_pop[w_in_vid]);
    for (int i = 0; i < NUM_VC; i++) begin
      w_wr[i] = w_accept && (w_in_vid == VID_BITS'(i));
    end
  end

  // Only the lowest-index requesting VC may pop per cycle.
  assign w_sa_valid = sa_gnt & sa_req;
  assign w_pop      = w_sa_valid & (~w_sa_valid + NUM_VC'(1));
  assign w_sel_any  = |w_pop;

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (w_pop[i]) w_sel_idx = VID_BITS'(i);
    end
    w_fwd_flit = w_head[w_sel_idx];
    w_fwd_flit[D_WIDTH-1 -: VID_BITS] = r_ovid[w_sel_idx];
  end

  // Per-VC state machine: register, next-state, outputs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (rst) r_state[i] <= c_st_rc;
      else     r_state[i] <= w_state_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        c_st_rc:  if (rc_gnt[i] && rc_req[i]) w_state_nxt[i] = c_st_va;
        c_st_va:  if (va_gnt[i] && va_req[i]) w_state_nxt[i] = c_st_act;
        c_st_act: if (w_pop[i] && !w_head[i][c_type_msb]) w_state_nxt[i] = c_st_rc;
        default:  w_state_nxt[i] = c_st_rc;
      endcase
    end
  end

  always_comb begin
    rc_req = '0;
    va_req = '0;
    sa_req = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      rc_req[i] = (r_state[i] == c_st_rc)  && !w_empty[i];
      va_req[i] = (r_state[i] == c_st_va)  && !w_empty[i];
      sa_req[i] = (r_state[i] == c_st_act) && !w_empty[i];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[w_in_vid][r_wr_ptr[w_in_vid]] <= in_flit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
        r_route[i]  <= '0;
        r_ovid[i]   <= '0;
      end
      ovf_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (rc_gnt[i] && rc_req[i]) r_route[i] <= rc_route_i;
        if (va_gnt[i] && va_req[i]) r_ovid[i]  <= va_ovid_i;
        if (w_wr[i])  r_wr_ptr[i] <= r_wr_ptr[i] + c_ptr_bits'(1);
        if (w_pop[i]) r_rd_ptr[i] <= r_rd_ptr[i] + c_ptr_bits'(1);
        if (w_wr[i] && !w_pop[i])      r_count[i] <= r_count[i] + CNT_BITS'(1);
        else if (!w_wr[i] && w_pop[i]) r_count[i] <= r_count[i] - CNT_BITS'(1);
      end
      if (in_valid && !w_accept) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_flit     <= '0;
      out_route    <= '0;
      credit_valid <= 1'b0;
      credit_vid   <= '0;
    end else begin
      out_valid    <= w_sel_any;
      credit_valid <= w_sel_any;
      if (w_sel_any) begin
        out_flit   <= w_fwd_flit;
        out_route  <= r_route[w_sel_idx];
        credit_vid <= w_sel_idx;
      end
    end
  end

`ifdef NOC_IU_PROTO_CHECK_EN
  logic [1:0]        w_in_type;
  logic [NUM_VC-1:0] r_last_open;
  logic              w_proto_hit;

  assign w_in_type = in_flit[c_type_msb -: 2];

  always_comb begin
    w_proto_hit = |(rc_gnt & ~rc_req) | |(va_gnt & ~va_req) | |(sa_gnt & ~sa_req);
    if (w_accept) begin
      // Body/tail opening a packet, or head/single arriving inside one.
      if ((^w_in_type) && w_empty[w_in_vid] && (r_state[w_in_vid] == c_st_rc))
        w_proto_hit = 1'b1;
      if (!(^w_in_type) && r_last_open[w_in_vid])
        w_proto_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_open <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (w_accept) r_last_open[w_in_vid] <= w_in_type[1];
      if (w_proto_hit) proto_err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_vc_input_unit.sv
// Bench for noc_vc_input_unit: directed scenarios then random traffic, checked
// against a packet-level model (per-VC queues plus route/VC ownership flags).
`default_nettype none

module tb_noc_vc_input_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_flit = '0;
  logic [3:0]  rc_req, va_req, sa_req;
  logic [3:0]  rc_gnt = '0, va_gnt = '0, sa_gnt = '0;
  logic [3:0]  rc_route_i = '0;
  logic [1:0]  va_ovid_i = '0;
  logic        out_valid, credit_valid, ovf_err;
  logic [31:0] out_flit;
  logic [3:0]  out_route;
  logic [1:0]  credit_vid;
  logic [11:0] vc_count;
`ifdef NOC_IU_PROTO_CHECK_EN
  logic        proto_err;
`endif

  noc_vc_input_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
    .rc_req(rc_req), .rc_gnt(rc_gnt), .rc_route_i(rc_route_i),
    .va_req(va_req), .va_gnt(va_gnt), .va_ovid_i(va_ovid_i),
    .sa_req(sa_req), .sa_gnt(sa_gnt),
    .out_valid(out_valid), .out_flit(out_flit), .out_route(out_route),
    .credit_valid(credit_valid), .credit_vid(credit_vid),
    .vc_count(vc_count),
`ifdef NOC_IU_PROTO_CHECK_EN
    .proto_err(proto_err),
`endif
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: buffered flits per VC and whether the packet at the head
  // already owns a route and an output VC.
  logic [31:0] mq [4][$];
  logic        has_route [4];
  logic        has_vc    [4];
  logic [3:0]  m_route   [4];
  logic [1:0]  m_ovid    [4];
  logic        e_ov, e_cv, e_ovf;
  logic [31:0] e_flit;
  logic [3:0]  e_route;
  logic [1:0]  e_cvid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int vid, input int typ, input int pay);
    logic [31:0] f;
    f = 32'(pay);
    f[31:30] = 2'(vid);
    f[29:28] = 2'(typ);
    return f;
  endfunction

  function automatic void model_reqs(output logic [3:0] r, output logic [3:0] v, output logic [3:0] s);
    r = '0; v = '0; s = '0;
    for (int i = 0; i < 4; i++) begin
      r[i] = (mq[i].size() != 0) && !has_route[i];
      v[i] = (mq[i].size() != 0) && has_route[i] && !has_vc[i];
      s[i] = (mq[i].size() != 0) && has_vc[i];
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      has_route[i] = 1'b0;
      has_vc[i]    = 1'b0;
      m_route[i]   = '0;
      m_ovid[i]    = '0;
    end
    e_ov = 0; e_cv = 0; e_ovf = 0; e_flit = '0; e_route = '0; e_cvid = '0;
  endtask

  task automatic step();
    logic [3:0]  r, v, s, cand;
    logic [11:0] ecnt;
    logic [31:0] f;
    logic        was_rst;
    int          k, vid;
    model_reqs(r, v, s);
    chk("rc_req", 64'(rc_req), 64'(r));
    chk("va_req", 64'(va_req), 64'(v));
    chk("sa_req", 64'(sa_req), 64'(s));
    @(posedge clk);
    was_rst = rst;
    if (rst) begin
      model_clear();
    end else begin
      k = -1;
      cand = sa_gnt & s;
      for (int i = 0; i < 4; i++) if (cand[i] && k < 0) k = i;
      e_ov = (k >= 0);
      e_cv = (k >= 0);
      for (int i = 0; i < 4; i++) begin
        if (rc_gnt[i] && r[i]) begin has_route[i] = 1'b1; m_route[i] = rc_route_i; end
        if (va_gnt[i] && v[i]) begin has_vc[i] = 1'b1; m_ovid[i] = va_ovid_i; end
      end
      if (k >= 0) begin
        f = mq[k].pop_front();
        if (!f[29]) begin has_route[k] = 1'b0; has_vc[k] = 1'b0; end
        f[31:30] = m_ovid[k];
        e_flit  = f;
        e_route = m_route[k];
        e_cvid  = 2'(k);
      end
      if (in_valid) begin
        vid = int'(in_flit[31:30]);
        if (mq[vid].size() < 4 || k == vid) mq[vid].push_back(in_flit);
        else e_ovf = 1'b1;
      end
    end
    #1;
    ecnt = '0;
    for (int i = 0; i < 4; i++) ecnt[i*3 +: 3] = 3'(mq[i].size());
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("credit_valid", 64'(credit_valid), 64'(e_cv));
    chk("vc_count", 64'(vc_count), 64'(ecnt));
    chk("ovf_err", 64'(ovf_err), 64'(e_ovf));
    if (e_ov || was_rst) begin
      chk("out_flit", 64'(out_flit), 64'(e_flit));
      chk("out_route", 64'(out_route), 64'(e_route));
      chk("credit_vid", 64'(credit_vid), 64'(e_cvid));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] f, input logic [3:0] rg,
                       input logic [3:0] vg, input logic [3:0] sg);
    in_valid = v; in_flit = f; rc_gnt = rg; va_gnt = vg; sa_gnt = sg;
    step();
    in_valid = 0; rc_gnt = '0; va_gnt = '0; sa_gnt = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset();

    // Single-flit packet on VC2, output VC 1.
    drive(1, mk(2, 0, 'h123), 0, 0, 0);
    rc_route_i = 4'd5;
    drive(0, 0, 4'b0100, 0, 0);
    va_ovid_i = 2'd1;
    drive(0, 0, 0, 4'b0100, 0);
    drive(0, 0, 0, 0, 4'b0100);
    chk("t1_out_vid", 64'(out_flit[31:30]), 64'd1);
    chk("t1_credit_vid", 64'(credit_vid), 64'd2);
    drive(0, 0, 0, 0, 0);

    // Interleaved packets on VC0 (H,B,T) and VC3 (H,T).
    drive(1, mk(0, 3, 'h10), 0, 0, 0);
    drive(1, mk(3, 3, 'h30), 0, 0, 0);
    drive(1, mk(0, 2, 'h11), 0, 0, 0);
    drive(1, mk(3, 1, 'h31), 0, 0, 0);
    drive(1, mk(0, 1, 'h12), 0, 0, 0);
    rc_route_i = 4'd9;
    drive(0, 0, 4'b1001, 0, 0);
    va_ovid_i = 2'd2;
    drive(0, 0, 0, 4'b1001, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 4'b1001);

    // Fill VC1, overflow, then write into the full VC while it pops.
    drive(1, mk(1, 3, 'h20), 0, 0, 0);
    for (int i = 1; i < 4; i++) drive(1, mk(1, 2, 'h20 + i), 0, 0, 0);
    drive(1, mk(1, 2, 'h2f), 0, 0, 0);
    chk("t3_ovf", 64'(ovf_err), 64'd1);
    rc_route_i = 4'd3;
    drive(0, 0, 4'b0010, 0, 0);
    va_ovid_i = 2'd0;
    drive(0, 0, 0, 4'b0010, 0);
    drive(1, mk(1, 2, 'h25), 0, 0, 4'b0010);
    chk("t3_cnt_full", 64'(vc_count[5:3]), 64'd4);

    // Two VCs in ACT with multi-bit switch grant.
    drive(1, mk(2, 3, 'h40), 0, 0, 0);
    drive(0, 0, 4'b0100, 0, 0);
    va_ovid_i = 2'd3;
    drive(0, 0, 0, 4'b0100, 0);
    drive(0, 0, 0, 0, 4'b0110);
    chk("t4_credit_vid", 64'(credit_vid), 64'd1);

    // Reset with flits buffered mid-packet.
    drive(0, 0, 0, 0, 4'b0010);
    do_reset();
    chk("t5_count", 64'(vc_count), 64'd0);
    drive(0, 0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rc_route_i = 4'($urandom);
      va_ovid_i  = 2'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 2) != 0),
              mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 'hfff)),
              ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0,
              ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0,
              4'($urandom));
      end
    end

`ifdef NOC_IU_PROTO_CHECK_EN
    do_reset();
    chk("proto_rst", 64'(proto_err), 64'd0);
    drive(1, mk(0, 2, 'h77), 0, 0, 0);
    chk("proto_set", 64'(proto_err), 64'd1);
    drive(0, 0, 0, 0, 0);
    chk("proto_hold", 64'(proto_err), 64'd1);
    do_reset();
    chk("proto_clr", 64'(proto_err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
